// File: rtl/store_reservation_station_pkg.sv
// Shared constants, types and the CDB slot selector for the store reservation station.
// Tags are function-unit numbers; tag 0 is reserved to mean "operand already ready".
package store_reservation_station_pkg;

  localparam int OPCODE_LENGTH            = 6;
  localparam logic [OPCODE_LENGTH-1:0] OPCODE_SW = 6'b101011;
  localparam int REORDER_BUFFER_SIZE_LOG  = 4;
  localparam int FUNCTION_UNIT_NUMBER     = 16;
  localparam int FUNCTION_UNIT_NUMBER_LOG = 4;
  localparam int WORD_W                   = 32;
  localparam int CDB_W                    = FUNCTION_UNIT_NUMBER * WORD_W;

  typedef logic [FUNCTION_UNIT_NUMBER_LOG-1:0] tag_t;
  typedef logic [WORD_W-1:0]                   word_t;
  typedef logic [REORDER_BUFFER_SIZE_LOG-1:0]  rob_pos_t;

  localparam tag_t TAG_READY = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } rs_state_e;

  // Slot u of the bus occupies bits [32u+31:32u].
  function automatic word_t cdb_slot(input logic [CDB_W-1:0] bus, input tag_t tag);
    word_t slot;
    slot = '0;
    for (int u = 0; u < FUNCTION_UNIT_NUMBER; u++) begin
      if (tag == tag_t'(u)) begin
        slot = bus[u*WORD_W +: WORD_W];
      end
    end
    return slot;
  endfunction

endpackage

// File: rtl/store_reservation_station_operand_capture.sv
// One operand slot: holds value, producer tag and pending flag, and pulls the
// producer's result off the CDB when told to capture.
module store_reservation_station_operand_capture
  import store_reservation_station_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  tag_t             tag_in,
  input  word_t            value_in,
  input  logic             capture,
  input  logic [CDB_W-1:0] cdb,
  output word_t            value,
  output logic             resolved
);

  tag_t tag;
  logic pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value   <= '0;
      tag     <= TAG_READY;
      pending <= 1'b0;
    end else if (load) begin
      value   <= value_in;
      tag     <= tag_in;
      pending <= (tag_in != TAG_READY);
    end else if (capture && pending) begin
      value   <= cdb_slot(cdb, tag);
      pending <= 1'b0;
    end
  end

  // Resolved after this edge: either nothing pending, or the capture lands now.
  assign resolved = !pending || capture;

endmodule

// File: rtl/store_reservation_station.sv
// Single-entry reservation station for SW: issue, resolve operands from the CDB,
// then present ROB position, effective address and store data to the write buffer.
module store_reservation_station
  import store_reservation_station_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic [OPCODE_LENGTH-1:0]            op,
  input  logic [REORDER_BUFFER_SIZE_LOG-1:0]  pos,
  input  logic [FUNCTION_UNIT_NUMBER_LOG-1:0] qi,
  input  logic [31:0]                         vi,
  input  logic [FUNCTION_UNIT_NUMBER_LOG-1:0] qj,
  input  logic [31:0]                         vj,
  input  logic [FUNCTION_UNIT_NUMBER_LOG-1:0] qk,
  input  logic [31:0]                         vk,
  input  logic [FUNCTION_UNIT_NUMBER*32-1:0]  commonDataBus,
  output logic                                busy,
  output logic [REORDER_BUFFER_SIZE_LOG-1:0]  writeBuffer_position,
  output logic [31:0]                         writeBuffer_value,
  output logic [31:0]                         writeBuffer_storeValue
);

  rs_state_e state;
  rob_pos_t  pos_p0;
  logic      issue;
  logic      capture;
  logic      all_resolved;
  word_t     val_i;
  word_t     val_j;
  word_t     val_k;
  logic      res_i;
  logic      res_j;
  logic      res_k;

  // Issue is only considered while the entry is free.
  assign issue   = (state == ST_IDLE) && (op == OPCODE_SW);
  assign capture = (state == ST_WAIT);

  store_reservation_station_operand_capture u_data (
    .clk      (clk),
    .reset    (reset),
    .load     (issue),
    .tag_in   (qi),
    .value_in (vi),
    .capture  (capture),
    .cdb      (commonDataBus),
    .value    (val_i),
    .resolved (res_i)
  );

  store_reservation_station_operand_capture u_base (
    .clk      (clk),
    .reset    (reset),
    .load     (issue),
    .tag_in   (qj),
    .value_in (vj),
    .capture  (capture),
    .cdb      (commonDataBus),
    .value    (val_j),
    .resolved (res_j)
  );

  store_reservation_station_operand_capture u_offset (
    .clk      (clk),
    .reset    (reset),
    .load     (issue),
    .tag_in   (qk),
    .value_in (vk),
    .capture  (capture),
    .cdb      (commonDataBus),
    .value    (val_k),
    .resolved (res_k)
  );

  assign all_resolved = res_i & res_j & res_k;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= ST_IDLE;
      busy                   <= 1'b0;
      pos_p0                 <= '0;
      writeBuffer_position   <= '0;
      writeBuffer_value      <= '0;
      writeBuffer_storeValue <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            pos_p0 <= pos;
            busy   <= 1'b1;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (all_resolved) begin
            state <= ST_DONE;
          end
        end
        // busy falling together with the new outputs is the write-buffer strobe
        ST_DONE: begin
          writeBuffer_position   <= pos_p0;
          writeBuffer_value      <= val_j + val_k;
          writeBuffer_storeValue <= val_i;
          busy                   <= 1'b0;
          state                  <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_reservation_station.sv
// Directed plus randomized checks of the SW reservation station against a
// transaction-level model: expected address = eff(j)+eff(k), data = eff(i).
module tb_store_reservation_station;

  localparam logic [5:0] SW = 6'b101011;

  logic         clk;
  logic         reset;
  logic [5:0]   op;
  logic [3:0]   pos;
  logic [3:0]   qi;
  logic [31:0]  vi;
  logic [3:0]   qj;
  logic [31:0]  vj;
  logic [3:0]   qk;
  logic [31:0]  vk;
  logic [511:0] cdb_bus;
  logic         busy;
  logic [3:0]   wb_pos;
  logic [31:0]  wb_val;
  logic [31:0]  wb_sv;

  logic [31:0]  slots [16];
  int           n_assert;
  int           n_fail;
  logic [31:0]  exp_pos;
  logic [31:0]  exp_val;
  logic [31:0]  exp_sv;

  store_reservation_station dut (
    .clk                    (clk),
    .reset                  (reset),
    .op                     (op),
    .pos                    (pos),
    .qi                     (qi),
    .vi                     (vi),
    .qj                     (qj),
    .vj                     (vj),
    .qk                     (qk),
    .vk                     (vk),
    .commonDataBus          (cdb_bus),
    .busy                   (busy),
    .writeBuffer_position   (wb_pos),
    .writeBuffer_value      (wb_val),
    .writeBuffer_storeValue (wb_sv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load_bus();
    for (int u = 0; u < 16; u++) cdb_bus[u*32 +: 32] = slots[u];
  endtask

  function automatic logic [5:0] non_sw();
    logic [5:0] o;
    o = 6'($urandom_range(0, 63));
    if (o == SW) o = 6'd0;
    return o;
  endfunction

  // Operand as the station should see it: the given value, or its producer's broadcast.
  function automatic logic [31:0] eff(input logic [3:0] q, input logic [31:0] v);
    return (q == 4'd0) ? v : slots[q];
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pos"}, 32'(wb_pos), exp_pos);
    check({tag, "_val"}, wb_val, exp_val);
    check({tag, "_sv"}, wb_sv, exp_sv);
  endtask

  task automatic run_store(input logic [3:0] p, input logic [3:0] ti, input logic [31:0] xi,
                           input logic [3:0] tj, input logic [31:0] xj,
                           input logic [3:0] tk, input logic [31:0] xk, input bit noise);
    logic [31:0] n_val;
    logic [31:0] n_sv;
    n_sv  = eff(ti, xi);
    n_val = eff(tj, xj) + eff(tk, xk);
    op = SW; pos = p; qi = ti; vi = xi; qj = tj; vj = xj; qk = tk; vk = xk;
    load_bus();
    @(posedge clk); #1;
    check("busy_after_issue", 32'(busy), 32'd1);
    op  = noise ? SW : non_sw();
    pos = 4'($urandom_range(0, 15));
    qi = 4'($urandom_range(0, 15)); vi = $urandom;
    qj = 4'($urandom_range(0, 15)); vj = $urandom;
    qk = 4'($urandom_range(0, 15)); vk = $urandom;
    @(posedge clk); #1;
    check("busy_in_wait", 32'(busy), 32'd1);
    check("hold_val", wb_val, exp_val);
    check("hold_sv", wb_sv, exp_sv);
    @(posedge clk); #1;
    op = 6'd0;
    exp_pos = 32'(p);
    exp_val = n_val;
    exp_sv  = n_sv;
    check_outputs("complete");
  endtask

  task automatic idle_cycle();
    op  = non_sw();
    pos = 4'($urandom_range(0, 15));
    qi = 4'd0; vi = $urandom; qj = 4'd0; vj = $urandom; qk = 4'd0; vk = $urandom;
    @(posedge clk); #1;
    check_outputs("idle");
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    exp_pos = 0; exp_val = 0; exp_sv = 0;
    for (int u = 0; u < 16; u++) slots[u] = $urandom;
    load_bus();
    op = 6'd0; pos = 4'd0; qi = 4'd0; vi = 0; qj = 4'd0; vj = 0; qk = 4'd0; vk = 0;
    reset = 1'b1;
    #12;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Ready operands
    run_store(4'd0, 4'd0, 32'd0, 4'd0, 32'd5, 4'd0, 32'd7, 1'b0);
    check("ready_val", wb_val, 32'd12);
    idle_cycle();

    // Pending base on slot 2
    slots[2] = 32'd5;
    run_store(4'd3, 4'd0, 32'd1, 4'd2, 32'hBAD0_BAD0, 4'd0, 32'd7, 1'b1);
    check("pend_base_val", wb_val, 32'd12);
    idle_cycle();

    // Pending store data on slot 4
    slots[4] = 32'hDEADBEEF;
    run_store(4'd6, 4'd4, 32'h1234_5678, 4'd0, 32'h100, 4'd0, 32'd4, 1'b0);
    check("pend_data_sv", wb_sv, 32'hDEADBEEF);
    check("pend_data_val", wb_val, 32'h104);

    // Address overflow wraps; SW arriving while busy is ignored
    run_store(4'd15, 4'd0, 32'hCAFE_F00D, 4'd0, 32'hFFFF_FFFF, 4'd0, 32'd2, 1'b1);
    check("overflow_val", wb_val, 32'd1);
    for (int c = 0; c < 3; c++) idle_cycle();

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      logic [3:0] ti, tj, tk;
      for (int u = 0; u < 16; u++) slots[u] = $urandom;
      ti = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      tj = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      tk = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      run_store(4'($urandom_range(0, 15)), ti, $urandom, tj, $urandom, tk, $urandom,
                1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
    end

    // Reset in the middle of WAIT with address 12 pending: no completion follows
    slots[2] = 32'd5;
    load_bus();
    op = SW; pos = 4'd9; qi = 4'd0; vi = 32'd77; qj = 4'd2; vj = 32'd0; qk = 4'd0; vk = 32'd7;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 32'd1);
    op = 6'd0;
    #2 reset = 1'b1;
    #1;
    exp_pos = 0; exp_val = 0; exp_sv = 0;
    check_outputs("mid_reset");
    #2 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_outputs("after_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
